tt_um_jleugeri_ttt_prog_sequencer: RTL and testbench
====================================================

TT_UM_JLEUGERI_TTT_PROG_SEQUENCER -- requirements
Module: tt_um_jleugeri_ttt_prog_sequencer

Interface
REQ-001 Parameters: PROG_WIDTH, default 8, width of prog_data and of every stream byte.
REQ-002 Parameters: NUM_PROCESSORS, default 10, number of addressable processor cores; ID_BITS = ceil(log2(NUM_PROCESSORS)).
REQ-003 clock_fast  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 hold  input  1  pauses stream acceptance and instruction issue while high.
REQ-006 in_data  input  PROG_WIDTH  programming stream byte.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  sequencer accepts in_data this cycle; a transfer occurs when in_valid and in_ready are both high.
REQ-009 instruction  output  3  opcode to the processor core; 0 = no operation.
REQ-010 prog_data  output  PROG_WIDTH  operand for instruction.
REQ-011 neuron_id  output  ID_BITS  target processor for instruction.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 packet_done  output  1  one-cycle pulse when a packet completes or is discarded.
REQ-014 error  output  1  sticky flag, set on an addressing fault.

Function
REQ-015 Packet format: header byte (bits 7:5 = opcode, bits 4:0 ignored), start-id byte, count byte N (0..255), then N data bytes.
REQ-016 States: IDLE (await header), ADDR (await start id), COUNT (await N), DATA (stream data), DROP (discard data).
REQ-017 in_ready SHALL equal NOT hold in every state.
REQ-018 IDLE: an accepted header with opcode 0 SHALL be consumed with no state change and no packet_done.
REQ-019 IDLE: an accepted header with a nonzero opcode SHALL latch the opcode and go to ADDR.
REQ-020 ADDR: the accepted byte SHALL be latched as the current id; go to COUNT.
REQ-021 COUNT: N = 0 SHALL pulse packet_done and go to IDLE.
REQ-022 COUNT: N > 0 with current id < NUM_PROCESSORS SHALL go to DATA.
REQ-023 COUNT: N > 0 with current id >= NUM_PROCESSORS SHALL set error and go to DROP.
REQ-024 DATA: each accepted byte SHALL, on the next cycle, drive instruction = opcode, prog_data = byte and neuron_id = current id for exactly one cycle (latency 1). The current id SHALL then increment and the remaining count SHALL decrement.
REQ-025 DATA: if the incremented id reaches NUM_PROCESSORS while the remaining count is nonzero, error SHALL be set and the state SHALL go to DROP.
REQ-026 DATA/DROP: acceptance of the last counted byte SHALL pulse packet_done in the same cycle as the last issue (DATA) or on the next cycle (DROP), then go to IDLE.
REQ-027 DROP: bytes SHALL be accepted and counted with no issue.
REQ-028 instruction SHALL be 0 in every cycle with no issue.
REQ-029 prog_data and neuron_id SHALL hold their last values when no instruction is issued.
REQ-030 hold high: no transfer occurs and the state, counters and error are frozen. An issue already registered from the previous cycle's transfer SHALL still appear.
REQ-031 Arithmetic: the remaining count SHALL be 8-bit and never underflow. The current id SHALL be compared at full PROG_WIDTH width, so it cannot alias by wrap-around.
REQ-032 A header byte arriving while busy SHALL be treated as whatever field the current state expects; there is no resynchronisation other than reset.

Reset
REQ-033 While reset is high, the next clock edge SHALL force: state IDLE, instruction 0, prog_data 0, neuron_id 0, busy 0, packet_done 0, error 0, in_ready 0.
REQ-034 Reset SHALL override hold and in_valid.
REQ-035 Reset asserted mid-packet SHALL abandon the packet with no further issue and no packet_done.
REQ-036 After reset deasserts, the first accepted byte SHALL be treated as a header.

Verification
REQ-037 Scenario: stream 0x60, 0x02, 0x03, 0xA1, 0xA2, 0xA3 with no hold -> instruction 3 with (id 2, 0xA1), (id 3, 0xA2), (id 4, 0xA3) on three consecutive cycles, each one cycle after its byte; packet_done with the last; error 0.
REQ-038 Scenario: stream 0x20, 0x08, 0x04, then 4 data bytes -> issues at ids 8 and 9, error set, last 2 bytes dropped, packet_done once, then IDLE.
REQ-039 Scenario: stream 0x40, 0x0C, 0x02, 2 bytes -> no issue, error 1, packet_done once; a following valid packet still issues and error stays 1.
REQ-040 Scenario: stream 0x00, 0xE0, 0x01, 0x00 -> first byte ignored; opcode 7 packet with N = 0 pulses packet_done, no issue.
REQ-041 Scenario: hold high for 3 cycles mid-DATA with in_valid high -> in_ready 0, no new issue, count preserved; the sequence resumes intact when hold drops.
REQ-042 Scenario: reset pulsed after the 2nd data byte of an N = 5 packet -> all outputs 0 next cycle; a new header is accepted afterwards.

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_prog_sequencer.sv
// -----------------------------------------------------------------------------
// tt_um_jleugeri_ttt_prog_sequencer
//
// Programming-stream sequencer. It parses a byte stream of packets of the form
//   header (opcode in bits 7:5) | start id | count N | N data bytes
// and turns each data byte into one instruction for one processor core,
// walking the core id upward from the start id. If a packet addresses a core
// that does not exist, the sticky error flag is raised and the rest of the
// packet is swallowed.
//
// Ports
//   clock_fast   in   single clock, rising edge
//   reset        in   synchronous, active-high
//   hold         in   stalls acceptance and issue while high
//   in_data      in   [PROG_WIDTH-1:0] stream byte
//   in_valid     in   in_data valid
//   in_ready     out  byte accepted this cycle (transfer = in_valid & in_ready)
//   instruction  out  [2:0] opcode to the core, 0 = no operation
//   prog_data    out  [PROG_WIDTH-1:0] operand for instruction
//   neuron_id    out  [ID_BITS-1:0] target core for instruction
//   busy         out  high whenever a packet is in progress
//   packet_done  out  one-cycle pulse when a packet completes or is discarded
//   error        out  sticky addressing-fault flag
//
// PROG_WIDTH must be at least 8: the opcode sits in bits 7:5 and the count is
// an 8-bit field.
// -----------------------------------------------------------------------------
module tt_um_jleugeri_ttt_prog_sequencer #(
  parameter int PROG_WIDTH     = 8,
  parameter int NUM_PROCESSORS = 10,
  localparam int ID_BITS       = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1
) (
  input  logic                  clock_fast,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [PROG_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2:0]            instruction,
  output logic [PROG_WIDTH-1:0] prog_data,
  output logic [ID_BITS-1:0]    neuron_id,
  output logic                  busy,
  output logic                  packet_done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_DROP
  } state_t;

  // The id register is one bit wider than a stream byte so that incrementing
  // past the top byte value can never wrap back into the valid core range.
  localparam logic [PROG_WIDTH:0] NUM_P = (PROG_WIDTH+1)'(NUM_PROCESSORS);

  state_t                r_state;
  logic [2:0]            r_opcode;
  logic [PROG_WIDTH:0]   r_id;
  logic [7:0]            r_count;
  logic [2:0]            r_instruction;
  logic [PROG_WIDTH-1:0] r_prog_data;
  logic [ID_BITS-1:0]    r_neuron_id;
  logic                  r_packet_done;
  logic                  r_error;

  logic                  w_xfer;
  logic [PROG_WIDTH:0]   w_id_next;
  logic [7:0]            w_count_next;
  logic                  w_id_oob;
  logic                  w_id_next_oob;

  // Reset also masks ready so no byte is considered taken during reset.
  assign in_ready      = ~hold & ~reset;
  assign w_xfer        = in_valid & in_ready;

  assign w_id_next     = r_id + (PROG_WIDTH+1)'(1);
  assign w_id_oob      = (r_id >= NUM_P);
  assign w_id_next_oob = (w_id_next >= NUM_P);

  // Saturating decrement: the count is only nonzero in DATA/DROP, but the
  // guard keeps the field from ever underflowing.
  assign w_count_next  = (r_count != 8'd0) ? (r_count - 8'd1) : 8'd0;

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_opcode      <= '0;
      r_id          <= '0;
      r_count       <= '0;
      r_instruction <= '0;
      r_prog_data   <= '0;
      r_neuron_id   <= '0;
      r_packet_done <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      // Issue and done are single-cycle pulses; operand and id keep their
      // last values between issues.
      r_instruction <= '0;
      r_packet_done <= 1'b0;

      if (w_xfer) begin
        unique case (r_state)
          S_IDLE: begin
            // A zero opcode header is a filler byte: consumed, nothing else.
            if (in_data[7:5] != 3'd0) begin
              r_opcode <= in_data[7:5];
              r_state  <= S_ADDR;
            end
          end

          S_ADDR: begin
            r_id    <= {1'b0, in_data};
            r_state <= S_COUNT;
          end

          S_COUNT: begin
            r_count <= in_data[7:0];
            if (in_data[7:0] == 8'd0) begin
              r_packet_done <= 1'b1;
              r_state       <= S_IDLE;
            end else if (w_id_oob) begin
              r_error <= 1'b1;
              r_state <= S_DROP;
            end else begin
              r_state <= S_DATA;
            end
          end

          S_DATA: begin
            r_instruction <= r_opcode;
            r_prog_data   <= in_data;
            r_neuron_id   <= r_id[ID_BITS-1:0];
            r_id          <= w_id_next;
            r_count       <= w_count_next;
            // Finishing the packet takes priority: running off the end of
            // the core range only matters if more bytes are still owed.
            if (w_count_next == 8'd0) begin
              r_packet_done <= 1'b1;
              r_state       <= S_IDLE;
            end else if (w_id_next_oob) begin
              r_error <= 1'b1;
              r_state <= S_DROP;
            end
          end

          S_DROP: begin
            r_count <= w_count_next;
            if (w_count_next == 8'd0) begin
              r_packet_done <= 1'b1;
              r_state       <= S_IDLE;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign instruction = r_instruction;
  assign prog_data   = r_prog_data;
  assign neuron_id   = r_neuron_id;
  assign busy        = (r_state != S_IDLE);
  assign packet_done = r_packet_done;
  assign error       = r_error;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_prog_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for tt_um_jleugeri_ttt_prog_sequencer.
// Each vector drives one cycle of inputs, checks in_ready before the edge and
// the registered outputs just after it.
// -----------------------------------------------------------------------------
module tb_tt_um_jleugeri_ttt_prog_sequencer;

  logic       clk;
  logic       reset;
  logic       hold;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] instruction;
  logic [7:0] prog_data;
  logic [3:0] neuron_id;
  logic       busy;
  logic       packet_done;
  logic       error;

  tt_um_jleugeri_ttt_prog_sequencer #(
    .PROG_WIDTH    (8),
    .NUM_PROCESSORS(10)
  ) dut (
    .clock_fast (clk),
    .reset      (reset),
    .hold       (hold),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instruction(instruction),
    .prog_data  (prog_data),
    .neuron_id  (neuron_id),
    .busy       (busy),
    .packet_done(packet_done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic       h;
    logic [7:0] d;
    logic       rdy;
    logic [2:0] ins;
    logic [7:0] pd;
    logic [3:0] id;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic vec_t mk(input logic rst, input logic v, input logic h,
                              input logic [7:0] d, input logic rdy,
                              input logic [2:0] ins, input logic [7:0] pd,
                              input logic [3:0] id, input logic b,
                              input logic dn, input logic e);
    vec_t t;
    t.rst = rst; t.v = v; t.h = h; t.d = d; t.rdy = rdy; t.ins = ins;
    t.pd = pd; t.id = id; t.busy = b; t.done = dn; t.err = e;
    return t;
  endfunction

  // Called one time unit after a rising edge.
  task automatic apply(input vec_t t, input string name);
    logic rdy_seen;
    reset    = t.rst;
    in_valid = t.v;
    hold     = t.h;
    in_data  = t.d;
    #2;
    rdy_seen = in_ready;
    @(posedge clk);
    #1;
    n_vec++;
    if (rdy_seen !== t.rdy || instruction !== t.ins || prog_data !== t.pd ||
        neuron_id !== t.id || busy !== t.busy || packet_done !== t.done ||
        error !== t.err) begin
      n_miss++;
      $display("FAIL %s: got rdy=%b ins=%0d pd=%h id=%0d busy=%b done=%b err=%b, want rdy=%b ins=%0d pd=%h id=%0d busy=%b done=%b err=%b",
               name, rdy_seen, instruction, prog_data, neuron_id, busy, packet_done, error,
               t.rdy, t.ins, t.pd, t.id, t.busy, t.done, t.err);
    end
  endtask

  vec_t tbl[$];

  initial begin
    reset    = 1'b1;
    hold     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    //             rst v  h  data   rdy ins pd     id busy done err
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0)); // reset state
    // opcode 3 packet, ids 2..4
    tbl.push_back(mk(0, 1, 0, 8'h60, 1, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h02, 1, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h03, 1, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hA1, 1, 3, 8'hA1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hA2, 1, 3, 8'hA2, 3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hA3, 1, 3, 8'hA3, 4, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'hA3, 4, 0, 0, 0)); // outputs hold
    // nop header, then opcode 7 with N = 0
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 8'hA3, 4, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hE0, 1, 0, 8'hA3, 4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h01, 1, 0, 8'hA3, 4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 8'hA3, 4, 0, 1, 0));
    // start id 8, N = 4: runs off the end after id 9
    tbl.push_back(mk(0, 1, 0, 8'h20, 1, 0, 8'hA3, 4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h08, 1, 0, 8'hA3, 4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h04, 1, 0, 8'hA3, 4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hB1, 1, 1, 8'hB1, 8, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hB2, 1, 1, 8'hB2, 9, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'hB3, 1, 0, 8'hB2, 9, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'hB4, 1, 0, 8'hB2, 9, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'hB2, 9, 0, 0, 1));
    // reset clears error; start id 12 dropped whole, next packet still issues
    tbl.push_back(mk(1, 1, 0, 8'h40, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h40, 1, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h0C, 1, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h02, 1, 0, 8'h00, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'hC1, 1, 0, 8'h00, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'hC2, 1, 0, 8'h00, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'hA0, 1, 0, 8'h00, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h01, 1, 0, 8'h00, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8'h55, 1, 5, 8'h55, 0, 0, 1, 1));
    // reset overrides hold; last core (id 9) with N = 1 is not a fault
    tbl.push_back(mk(1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h20, 1, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h09, 1, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h01, 1, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h77, 1, 1, 8'h77, 9, 0, 1, 0));

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Hold for three cycles in the middle of a packet with valid held high.
    apply(mk(0, 1, 0, 8'h60, 1, 0, 8'h77, 9, 1, 0, 0), "hold_hdr");
    apply(mk(0, 1, 0, 8'h05, 1, 0, 8'h77, 9, 1, 0, 0), "hold_id");
    apply(mk(0, 1, 0, 8'h03, 1, 0, 8'h77, 9, 1, 0, 0), "hold_cnt");
    apply(mk(0, 1, 0, 8'h11, 1, 3, 8'h11, 5, 1, 0, 0), "hold_d0");
    for (int k = 0; k < 3; k++)
      apply(mk(0, 1, 1, 8'h22, 0, 0, 8'h11, 5, 1, 0, 0), $sformatf("hold_stall%0d", k));
    apply(mk(0, 1, 0, 8'h22, 1, 3, 8'h22, 6, 1, 0, 0), "hold_d1");
    apply(mk(0, 1, 0, 8'h33, 1, 3, 8'h33, 7, 0, 1, 0), "hold_d2");

    // Reset after the second data byte of an N = 5 packet.
    apply(mk(0, 1, 0, 8'h80, 1, 0, 8'h33, 7, 1, 0, 0), "rst_hdr");
    apply(mk(0, 1, 0, 8'h01, 1, 0, 8'h33, 7, 1, 0, 0), "rst_id");
    apply(mk(0, 1, 0, 8'h05, 1, 0, 8'h33, 7, 1, 0, 0), "rst_cnt");
    apply(mk(0, 1, 0, 8'hD1, 1, 4, 8'hD1, 1, 1, 0, 0), "rst_d0");
    apply(mk(0, 1, 0, 8'hD2, 1, 4, 8'hD2, 2, 1, 0, 0), "rst_d1");
    apply(mk(1, 1, 0, 8'hD3, 0, 0, 8'h00, 0, 0, 0, 0), "rst_pulse");
    apply(mk(0, 1, 0, 8'h60, 1, 0, 8'h00, 0, 1, 0, 0), "rst_newhdr");
    apply(mk(0, 1, 0, 8'h03, 1, 0, 8'h00, 0, 1, 0, 0), "rst_newid");
    apply(mk(0, 1, 0, 8'h01, 1, 0, 8'h00, 0, 1, 0, 0), "rst_newcnt");
    apply(mk(0, 1, 0, 8'h44, 1, 3, 8'h44, 3, 0, 1, 0), "rst_newdata");
    apply(mk(0, 0, 0, 8'h00, 1, 0, 8'h44, 3, 0, 0, 0), "rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
